// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, MIPS32 opcode/funct constants and
// the decoded-instruction record that travels through the issue stage.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_ADDU = 4'b0001,
        ALU_SUB  = 4'b0010,
        ALU_SUBU = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_LUI  = 4'b1111
    } alu_op_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_e     aluop;
        logic [4:0]  wr_reg;
        logic        wr_en;
        logic        illegal;
    } issue_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS32 ALU-instruction decoder: selects operands, ALU op and
// destination register, and flags anything it does not support.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_in,
    input  logic [31:0] rs_data_in,
    input  logic [31:0] rt_data_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [3:0]  aluop_out,
    output logic [4:0]  wr_reg_out,
    output logic        wr_en_out,
    output logic        illegal_out
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    alu_op_e     op;
    logic [4:0]  dst;
    logic        ill;
    logic        unused_fields;

    assign opcode   = instr_in[31:26];
    assign rt       = instr_in[20:16];
    assign rd       = instr_in[15:11];
    assign funct    = instr_in[5:0];
    assign imm_sext = {{16{instr_in[15]}}, instr_in[15:0]};
    assign imm_zext = {16'h0000, instr_in[15:0]};
    // rs index is resolved by the register file; shamt is unused by these ops
    assign unused_fields = ^{instr_in[25:21], instr_in[10:6]};

    always_comb begin
        op  = ALU_ADD;
        dst = rt;
        ill = 1'b0;
        b_out = rt_data_in;
        case (opcode)
            OPC_RTYPE: begin
                dst = rd;
                case (funct)
                    FN_ADD:  op = ALU_ADD;
                    FN_ADDU: op = ALU_ADDU;
                    FN_SUB:  op = ALU_SUB;
                    FN_SUBU: op = ALU_SUBU;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_XOR:  op = ALU_XOR;
                    FN_NOR:  op = ALU_NOR;
                    FN_SLT:  op = ALU_SLT;
                    FN_SLTU: op = ALU_SLTU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_ADDI:  begin op = ALU_ADD;  b_out = imm_sext; end
            OPC_ADDIU: begin op = ALU_ADDU; b_out = imm_sext; end
            OPC_SLTI:  begin op = ALU_SLT;  b_out = imm_sext; end
            OPC_SLTIU: begin op = ALU_SLTU; b_out = imm_sext; end
            OPC_ANDI:  begin op = ALU_AND;  b_out = imm_zext; end
            OPC_ORI:   begin op = ALU_OR;   b_out = imm_zext; end
            OPC_XORI:  begin op = ALU_XOR;  b_out = imm_zext; end
            OPC_LUI:   begin op = ALU_LUI;  b_out = imm_zext; end
            default:   ill = 1'b1;
        endcase
        // Unsupported words still flow downstream but must never write back
        if (ill) begin
            op  = ALU_ADD;
            dst = 5'd0;
        end
    end

    assign a_out       = rs_data_in;
    assign aluop_out   = op;
    assign wr_reg_out  = dst;
    assign wr_en_out   = !ill && (dst != 5'd0);
    assign illegal_out = ill;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction per cycle into a two-entry skid
// buffer (main + skid) with a registered upstream ready.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk_in,
    input  logic        rstn_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] rs_data_in,
    input  logic [31:0] rt_data_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        flush_in,
    output logic [31:0] A_out,
    output logic [31:0] B_out,
    output logic [3:0]  aluop_out,
    output logic [4:0]  wr_reg_out,
    output logic        wr_en_out,
    output logic        illegal_out,
    output logic        valid_out,
    input  logic        ready_in
);

    issue_t     dec;
    logic [3:0] dec_aluop;

    alu_ctrl_decode u_decode (
        .instr_in   (instr_in),
        .rs_data_in (rs_data_in),
        .rt_data_in (rt_data_in),
        .a_out      (dec.a),
        .b_out      (dec.b),
        .aluop_out  (dec_aluop),
        .wr_reg_out (dec.wr_reg),
        .wr_en_out  (dec.wr_en),
        .illegal_out(dec.illegal)
    );
    assign dec.aluop = alu_op_e'(dec_aluop);

    issue_t main_q, main_d, skid_q, skid_d;
    logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
    logic   in_xfer, out_xfer;

    assign in_xfer  = valid_in && rdy_q;
    assign out_xfer = main_vld_q && ready_in;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush_in) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_xfer) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (in_xfer) begin
                main_d = dec;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            // Main stalled: park the new entry in the skid slot
            if (main_vld_q) begin
                skid_d     = dec;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = dec;
                main_vld_d = 1'b1;
            end
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign ready_out   = rdy_q;
    assign valid_out   = main_vld_q;
    assign A_out       = main_q.a;
    assign B_out       = main_q.b;
    assign aluop_out   = main_q.aluop;
    assign wr_reg_out  = main_q.wr_reg;
    assign wr_en_out   = main_q.wr_en;
    assign illegal_out = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table streamed at full rate,
// then skid, flush and asynchronous-reset sequences.
module tb_alu_issue_stage;

    logic        clk_in = 1'b0;
    logic        rstn_in = 1'b0;
    logic [31:0] instr_in = '0;
    logic [31:0] rs_data_in = '0;
    logic [31:0] rt_data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        flush_in = 1'b0;
    logic [31:0] A_out, B_out;
    logic [3:0]  aluop_out;
    logic [4:0]  wr_reg_out;
    logic        wr_en_out, illegal_out, valid_out;
    logic        ready_in = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_stage dut (
        .clk_in(clk_in), .rstn_in(rstn_in), .instr_in(instr_in),
        .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
        .valid_in(valid_in), .ready_out(ready_out), .flush_in(flush_in),
        .A_out(A_out), .B_out(B_out), .aluop_out(aluop_out),
        .wr_reg_out(wr_reg_out), .wr_en_out(wr_en_out),
        .illegal_out(illegal_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        chk_ab;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  wr;
        logic        en;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        instr_in   = instr;
        rs_data_in = rs;
        rt_data_in = rt;
        valid_in   = 1'b1;
    endtask

    function automatic logic [127:0] outs(input logic chk_ab);
        return {52'd0, valid_out, chk_ab ? A_out : 32'd0, chk_ab ? B_out : 32'd0,
                aluop_out, wr_reg_out, wr_en_out, illegal_out};
    endfunction

    function automatic logic [127:0] exp_of(input vec_t v);
        return {52'd0, 1'b1, v.chk_ab ? v.a : 32'd0, v.chk_ab ? v.b : 32'd0,
                v.op, v.wr, v.en, v.ill};
    endfunction

    initial begin
        vec_t v;
        //                name        instr         rs            rt         ab  A             B             op     wr     en    ill
        vecs.push_back('{"addi",   32'h2025FFFF, 32'd7,        32'd0,     1, 32'd7,        32'hFFFFFFFF, 4'h0, 5'd5,  1'b1, 1'b0});
        vecs.push_back('{"ori",    32'h34028000, 32'd0,        32'd9,     1, 32'd0,        32'h00008000, 4'h5, 5'd2,  1'b1, 1'b0});
        vecs.push_back('{"lui",    32'h3C031234, 32'h55,       32'd0,     1, 32'h55,       32'h00001234, 4'hF, 5'd3,  1'b1, 1'b0});
        vecs.push_back('{"sltu",   32'h0022202B, 32'd1,        32'd2,     1, 32'd1,        32'd2,        4'hB, 5'd4,  1'b1, 1'b0});
        vecs.push_back('{"add_r0", 32'h00220020, 32'd3,        32'd4,     1, 32'd3,        32'd4,        4'h0, 5'd0,  1'b0, 1'b0});
        vecs.push_back('{"sub",    32'h01093822, 32'h100,      32'h20,    1, 32'h100,      32'h20,       4'h2, 5'd7,  1'b1, 1'b0});
        vecs.push_back('{"nor",    32'h0022F827, 32'hA,        32'hB,     1, 32'hA,        32'hB,        4'h7, 5'd31, 1'b1, 1'b0});
        vecs.push_back('{"slti",   32'h28268001, 32'h11,       32'd0,     1, 32'h11,       32'hFFFF8001, 4'hA, 5'd6,  1'b1, 1'b0});
        vecs.push_back('{"xori",   32'h3829F0F0, 32'h12,       32'd0,     1, 32'h12,       32'h0000F0F0, 4'h6, 5'd9,  1'b1, 1'b0});
        vecs.push_back('{"lw_ill", 32'h8C220004, 32'h13,       32'h14,    0, 32'd0,        32'd0,        4'h0, 5'd0,  1'b0, 1'b1});
        vecs.push_back('{"jr_ill", 32'h00200008, 32'h15,       32'h16,    0, 32'd0,        32'd0,        4'h0, 5'd0,  1'b0, 1'b1});
        vecs.push_back('{"andi_r0",32'h3020FFFF, 32'h17,       32'd0,     1, 32'h17,       32'h0000FFFF, 4'h4, 5'd0,  1'b0, 1'b0});
        vecs.push_back('{"addiu",  32'h244A7FFF, 32'h18,       32'd0,     1, 32'h18,       32'h00007FFF, 4'h1, 5'd10, 1'b1, 1'b0});
        vecs.push_back('{"slt",    32'h0022282A, 32'h19,       32'h1A,    1, 32'h19,       32'h1A,       4'hA, 5'd5,  1'b1, 1'b0});
        vecs.push_back('{"addu",   32'h00220821, 32'h1B,       32'h1C,    1, 32'h1B,       32'h1C,       4'h1, 5'd1,  1'b1, 1'b0});
        vecs.push_back('{"and",    32'h00221024, 32'h1D,       32'h1E,    1, 32'h1D,       32'h1E,       4'h4, 5'd2,  1'b1, 1'b0});
        vecs.push_back('{"or",     32'h00221825, 32'h1F,       32'h20,    1, 32'h1F,       32'h20,       4'h5, 5'd3,  1'b1, 1'b0});
        vecs.push_back('{"xor",    32'h00222026, 32'h21,       32'h22,    1, 32'h21,       32'h22,       4'h6, 5'd4,  1'b1, 1'b0});
        vecs.push_back('{"subu",   32'h00222823, 32'h23,       32'h24,    1, 32'h23,       32'h24,       4'h3, 5'd5,  1'b1, 1'b0});

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_outputs", {51'd0, valid_out, ready_out, A_out, B_out, aluop_out, wr_reg_out, wr_en_out, illegal_out}, 128'd0);
        rstn_in = 1'b1;
        #1 chk("rst_rdy_before_edge", {127'd0, ready_out}, 128'd0);
        @(negedge clk_in);
        chk("rst_rdy_after_edge", {126'd0, ready_out, valid_out}, 128'd2);

        // Decode table streamed back-to-back at one instruction per cycle
        ready_in = 1'b1;
        v = vecs[0];
        drive(v.instr, v.rs, v.rt);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_in);
            v = vecs[i];
            chk({"dec_", v.name}, outs(v.chk_ab), exp_of(v));
            chk({"rdy_", v.name}, {127'd0, ready_out}, 128'd1);
            if (i + 1 < vecs.size()) drive(vecs[i+1].instr, vecs[i+1].rs, vecs[i+1].rt);
            else valid_in = 1'b0;
        end
        @(negedge clk_in);
        chk("drain_empty", {127'd0, valid_out}, 128'd0);

        // Skid: three offers with downstream stalled, then release
        ready_in = 1'b0;
        drive(32'h00220020, 32'hA1, 32'd0);
        @(negedge clk_in);
        chk("skid_e1", {94'd0, ready_out, valid_out, A_out}, {94'd0, 1'b1, 1'b1, 32'hA1});
        drive(32'h00220020, 32'hA2, 32'd0);
        @(negedge clk_in);
        chk("skid_e2", {94'd0, ready_out, valid_out, A_out}, {94'd0, 1'b0, 1'b1, 32'hA1});
        drive(32'h00220020, 32'hA3, 32'd0);
        @(negedge clk_in);
        chk("skid_e3_hold", {94'd0, ready_out, valid_out, A_out}, {94'd0, 1'b0, 1'b1, 32'hA1});
        ready_in = 1'b1;
        @(negedge clk_in);
        chk("skid_out2", {94'd0, ready_out, valid_out, A_out}, {94'd0, 1'b1, 1'b1, 32'hA2});
        @(negedge clk_in);
        chk("skid_out3", {94'd0, ready_out, valid_out, A_out}, {94'd0, 1'b1, 1'b1, 32'hA3});
        valid_in = 1'b0;
        @(negedge clk_in);
        chk("skid_no_dup", {127'd0, valid_out}, 128'd0);

        // Flush with both entries full and a new input offered
        ready_in = 1'b0;
        drive(32'h00220020, 32'hB1, 32'd0);
        @(negedge clk_in);
        drive(32'h00220020, 32'hB2, 32'd0);
        @(negedge clk_in);
        chk("flush_pre", {126'd0, ready_out, valid_out}, 128'd1);
        flush_in = 1'b1;
        drive(32'h00220020, 32'hB3, 32'd0);
        @(negedge clk_in);
        chk("flush_post", {126'd0, ready_out, valid_out}, 128'd2);
        flush_in = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk_in);
        chk("flush_dropped", {127'd0, valid_out}, 128'd0);

        // Asynchronous reset mid-stream
        ready_in = 1'b0;
        drive(32'h3C031234, 32'hC1, 32'd0);
        @(negedge clk_in);
        drive(32'h3C031234, 32'hC2, 32'd0);
        @(negedge clk_in);
        valid_in = 1'b0;
        #2 rstn_in = 1'b0;
        #1 chk("arst_now", {51'd0, valid_out, ready_out, A_out, B_out, aluop_out, wr_reg_out, wr_en_out, illegal_out}, 128'd0);
        @(negedge clk_in);
        rstn_in = 1'b1;
        @(negedge clk_in);
        chk("arst_release", {126'd0, ready_out, valid_out}, 128'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL expose: clk_in  input  1  rising-edge clock.
REQ-002 The block SHALL expose: rstn_in  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL expose: instr_in  input  32  MIPS32 instruction word.
REQ-004 The block SHALL expose: rs_data_in  input  32  register-file value of rs.
REQ-005 The block SHALL expose: rt_data_in  input  32  register-file value of rt.
REQ-006 The block SHALL expose: valid_in  input  1 and ready_out  output  1, the upstream handshake.
REQ-007 The block SHALL expose: flush_in  input  1  to discard all held entries.
REQ-008 The block SHALL expose: A_out  output  32 and B_out  output  32, the ALU operands.
REQ-009 The block SHALL expose: aluop_out  output  4  ALU operation code.
REQ-010 The block SHALL expose: wr_reg_out  output  5 and wr_en_out  output  1, the destination register and its write enable.
REQ-011 The block SHALL expose: illegal_out  output  1  unsupported-instruction flag.
REQ-012 The block SHALL expose: valid_out  output  1 and ready_in  input  1, the downstream handshake.

Function
REQ-013 The aluop encoding SHALL be: 0000 ADD, 0001 ADDU, 0010 SUB, 0011 SUBU, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1010 SLT, 1011 SLTU, 1111 LUI.
REQ-014 R-type instructions (opcode 0x00) SHALL decode on funct: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU; for these B = rt_data and the destination = rd.
REQ-015 I-type instructions SHALL decode on opcode: 0x08 ADD, 0x09 ADDU, 0x0A SLT, 0x0B SLTU, each with sign-extended imm16; 0x0C AND, 0x0D OR, 0x0E XOR, 0x0F LUI, each with zero-extended imm16; for all of these the destination = rt.
REQ-016 A_out SHALL equal rs_data for every decoded instruction.
REQ-017 Any other opcode/funct SHALL set illegal_out=1, aluop_out=0000 and wr_en_out=0, and SHALL still occupy a slot and be handshaken normally.
REQ-018 wr_en_out SHALL be 0 whenever the destination is register 0 or the instruction is illegal.
REQ-019 An input transfer SHALL occur on a cycle where valid_in && ready_out; an output transfer SHALL occur on a cycle where valid_out && ready_in.
REQ-020 Latency SHALL be one cycle: an entry accepted at edge N is presented on the outputs after edge N.
REQ-021 Storage SHALL be a 2-entry skid buffer: a main register plus a skid register.
REQ-022 ready_out SHALL be registered and SHALL equal "skid empty".
REQ-023 With the main register full and ready_in=0, an accepted input SHALL go to the skid register and ready_out SHALL fall on the next cycle.
REQ-024 When the main register drains while the skid is full, the skid entry SHALL move to main on that edge and ready_out SHALL rise.
REQ-025 Simultaneous input and output transfers on a full main register with an empty skid SHALL replace main in place, with no bubble.
REQ-026 All outputs other than valid_out and ready_out SHALL be held stable while valid_out=1 and ready_in=0.
REQ-027 Sustained valid_in=ready_in=1 SHALL give throughput of 1 instruction per cycle.
REQ-028 flush_in=1 SHALL, at the next edge, clear both entries, drop any simultaneous input, and set ready_out=1; flush SHALL take priority over every other event.
REQ-029 Entry order SHALL be preserved (FIFO).

Reset
REQ-030 While rstn_in=0 the block SHALL hold valid_out=0, ready_out=0, both entries empty, and A_out, B_out, aluop_out, wr_reg_out, wr_en_out and illegal_out at 0.
REQ-031 ready_out SHALL rise on the first clock edge after rstn_in deasserts.
REQ-032 Reset asserted mid-transfer SHALL discard all entries immediately, asynchronously.

Structure
REQ-033 The aluop codes, opcode constants and funct constants SHALL live in the shared package alu_pkg, which the ALU also uses.
REQ-034 Decoding SHALL be one combinational sub-module, alu_ctrl_decode (instr, rs, rt -> A, B, aluop, wr_reg, wr_en, illegal), placed in front of the skid registers.

Verification
REQ-035 ADDI r5,r1,-1 (0x2025FFFF) with rs=7 -> A=7, B=0xFFFFFFFF, aluop=0000, wr_reg=5, wr_en=1.
REQ-036 ORI r2,r0,0x8000 -> B=0x00008000 (zero-extended), aluop=0101; LUI r3,0x1234 -> aluop=1111, B=0x00001234.
REQ-037 SLTU r4,r1,r2 (funct 0x2B) with rs=1, rt=2 -> aluop=1011, B=2, wr_reg=4; a write to r0 -> wr_en=0.
REQ-038 ready_in=0 with three valid inputs -> two are accepted and ready_out=0 from cycle 2; releasing ready_in -> the outputs appear in order, with no loss or duplication.
REQ-039 Opcode 0x23 (LW) -> illegal_out=1, wr_en=0, and it transfers normally; flush_in asserted with both entries full -> valid_out=0 and ready_out=1 on the next cycle.
REQ-040 rstn_in pulsed low mid-stream -> all outputs 0 immediately and ready_out=1 on the edge after release.
